uart_byte_rx: RTL



---
 rtl/uart_byte_rx.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, and a held byte that stays until clear.
// Define UART_BYTE_RX_PARITY_EN to receive 8E1 frames with an even-parity check.
// The held-byte port is named rx_byte because byte is a reserved word.
module uart_byte_rx #(
  parameter int CLOCK_FREQUENCY = 12000000,
  parameter int BAUD_RATE       = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       clear,
  output logic [7:0] rx_byte,
  output logic       byte_ready,
  output logic       busy,
  output logic       frame_error,
  output logic       overrun,
  output logic       parity_error
);

  localparam int DIV = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t          state_reg;
  logic [1:0]      sync_reg;
  logic            rx_prev_reg;
  logic [CW-1:0]   baud_cnt_reg;
  logic [2:0]      bit_idx_reg;
  logic [7:0]      shift_reg;
  logic            rx_s;
  logic            start_edge;
  logic            bit_tick;

  assign rx_s       = sync_reg[1];
  assign start_edge = rx_prev_reg & ~rx_s;
  assign bit_tick   = (baud_cnt_reg == BIT_LAST);

`ifdef UART_BYTE_RX_PARITY_EN
  logic parity_bad_reg;
  logic parity_error_reg;
  assign parity_error = parity_error_reg;
`else
  assign parity_error = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg     <= 2'b11;
      rx_prev_reg  <= 1'b1;
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      rx_byte      <= '0;
      byte_ready   <= 1'b0;
      busy         <= 1'b0;
      frame_error  <= 1'b0;
      overrun      <= 1'b0;
`ifdef UART_BYTE_RX_PARITY_EN
      parity_bad_reg   <= 1'b0;
      parity_error_reg <= 1'b0;
`endif
    end else begin
      sync_reg    <= {sync_reg[0], rx};
      rx_prev_reg <= rx_s;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
`ifdef UART_BYTE_RX_PARITY_EN
      parity_error_reg <= 1'b0;
`endif
      // A stop-bit accept later in this block overrides this clear.
      if (clear) begin
        byte_ready <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          baud_cnt_reg <= '0;
          if (start_edge) begin
            state_reg <= START;
            busy      <= 1'b1;
          end
        end

        START: begin
          if (baud_cnt_reg == HALF_LAST) begin
            baud_cnt_reg <= '0;
            if (rx_s) begin
              state_reg <= IDLE;
              busy      <= 1'b0;
            end else begin
              state_reg   <= DATA;
              bit_idx_reg <= '0;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end

        DATA: begin
          if (bit_tick) begin
            baud_cnt_reg <= '0;
            shift_reg    <= {rx_s, shift_reg[7:1]};
            bit_idx_reg  <= bit_idx_reg + 1'b1;
            if (bit_idx_reg == 3'd7) begin
`ifdef UART_BYTE_RX_PARITY_EN
              state_reg <= PARITY;
`else
              state_reg <= STOP;
`endif
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end

`ifdef UART_BYTE_RX_PARITY_EN
        PARITY: begin
          if (bit_tick) begin
            baud_cnt_reg   <= '0;
            parity_bad_reg <= ^{shift_reg, rx_s};
            state_reg      <= STOP;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
`endif

        STOP: begin
          if (bit_tick) begin
            baud_cnt_reg <= '0;
            if (!rx_s) begin
              frame_error <= 1'b1;
              state_reg   <= BREAK;
            end else begin
              state_reg <= IDLE;
              busy      <= 1'b0;
`ifdef UART_BYTE_RX_PARITY_EN
              if (parity_bad_reg) begin
                parity_error_reg <= 1'b1;
              end else
`endif
              if (!byte_ready || clear) begin
                rx_byte    <= shift_reg;
                byte_ready <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end

        // Hold here until the line returns high so a stuck-low line cannot retrigger.
        BREAK: begin
          baud_cnt_reg <= '0;
          if (rx_s) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        end

        default: begin
          state_reg    <= IDLE;
          busy         <= 1'b0;
          baud_cnt_reg <= '0;
        end
      endcase
    end
  end

endmodule
